parking_allocator: RTL and testbench

PARKING_ALLOCATOR -- requirements
Module: parking_allocator

---
 rtl/parking_allocator.sv | 134 +++++++++++++
 tb/tb_parking_allocator.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/parking_allocator.sv
// Four-spot parking lot entry controller: allocates the lowest free spot,
// runs the entry barrier for GATE_CYCLES cycles and tracks exits.
module parking_allocator #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_spot,
  output logic [3:0] occupancy,
  output logic [1:0] assigned_spot,
  output logic       entry_grant,
  output logic       entry_deny,
  output logic       gate_open,
  output logic       exit_err,
  output logic       full,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] occ_q, occ_d;
  logic [1:0] spot_q, spot_d;
  logic [3:0] gate_cnt_q, gate_cnt_d;
  logic [1:0] retry_q, retry_d;
  logic       grant_q, grant_d;
  logic       deny_q, deny_d;
  logic       gate_q, gate_d;
  logic       err_q, err_d;
  logic [1:0] free_idx;
  logic [3:0] alloc_mask;
  logic [3:0] free_mask;

  assign full = (occ_q == 4'b1111);

  always_comb begin
    if (!occ_q[0])      free_idx = 2'd0;
    else if (!occ_q[1]) free_idx = 2'd1;
    else if (!occ_q[2]) free_idx = 2'd2;
    else                free_idx = 2'd3;
  end

  always_comb begin
    state_d    = state_q;
    spot_d     = spot_q;
    gate_cnt_d = gate_cnt_q;
    retry_d    = 2'd0;
    grant_d    = 1'b0;
    deny_d     = 1'b0;
    err_d      = 1'b0;
    alloc_mask = 4'b0000;
    free_mask  = 4'b0000;

    case (state_q)
      IDLE: begin
        if (entry_req) begin
          if (full) begin
            // Deny on the first refused sample, then once every 4 cycles.
            retry_d = retry_q + 2'd1;
            deny_d  = (retry_q == 2'd0);
          end else begin
            state_d    = GRANT;
            grant_d    = 1'b1;
            spot_d     = free_idx;
            alloc_mask = 4'b0001 << free_idx;
          end
        end
      end
      GRANT: begin
        state_d    = OPEN;
        gate_cnt_d = GATE_LOAD;
      end
      OPEN: begin
        if (gate_cnt_q == 4'd0) state_d = HOLD;
        else                    gate_cnt_d = gate_cnt_q - 4'd1;
      end
      HOLD: begin
        if (!entry_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // exit_req is a single-cycle pulse qualifying exit_spot; accepted in every state.
    if (exit_req) begin
      if (occ_q[exit_spot]) free_mask[exit_spot] = 1'b1;
      else                  err_d = 1'b1;
    end

    occ_d  = (occ_q | alloc_mask) & ~free_mask;
    gate_d = (state_d == OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      occ_q      <= 4'b0000;
      spot_q     <= 2'b00;
      gate_cnt_q <= 4'd0;
      retry_q    <= 2'd0;
      grant_q    <= 1'b0;
      deny_q     <= 1'b0;
      gate_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      spot_q     <= spot_d;
      gate_cnt_q <= gate_cnt_d;
      retry_q    <= retry_d;
      grant_q    <= grant_d;
      deny_q     <= deny_d;
      gate_q     <= gate_d;
      err_q      <= err_d;
    end
  end

  assign occupancy     = occ_q;
  assign assigned_spot = spot_q;
  assign entry_grant   = grant_q;
  assign entry_deny    = deny_q;
  assign gate_open     = gate_q;
  assign exit_err      = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_parking_allocator.sv
// Directed, table-driven bench for parking_allocator plus hand-written
// sequences for asynchronous reset during the gate-open phase.
module tb_parking_allocator;

  localparam int GATE = 4;

  logic       clk;
  logic       rst_n;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_spot;
  logic [3:0] occupancy;
  logic [1:0] assigned_spot;
  logic       entry_grant;
  logic       entry_deny;
  logic       gate_open;
  logic       exit_err;
  logic       full;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  parking_allocator #(.GATE_CYCLES(GATE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .exit_spot     (exit_spot),
    .occupancy     (occupancy),
    .assigned_spot (assigned_spot),
    .entry_grant   (entry_grant),
    .entry_deny    (entry_deny),
    .gate_open     (gate_open),
    .exit_err      (exit_err),
    .full          (full),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       er;
    logic       xr;
    logic [1:0] xs;
    logic [3:0] occ;
    logic [1:0] as;
    logic       g;
    logic       d;
    logic       gt;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic er, input logic xr, input logic [1:0] xs,
                              input logic [3:0] occ, input logic [1:0] as,
                              input logic g, input logic d, input logic gt, input logic err);
    vec_t v;
    v.er = er; v.xr = xr; v.xs = xs; v.occ = occ; v.as = as;
    v.g = g; v.d = d; v.gt = gt; v.err = err;
    vecs.push_back(v);
  endfunction

  // One admitted car from IDLE: grant, GATE open cycles, HOLD, release.
  function automatic void add_car(input logic [3:0] occ, input logic [1:0] as);
    add(1'b1, 1'b0, 2'd0, occ, as, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < GATE; i++) add(1'b1, 1'b0, 2'd0, occ, as, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, occ, as, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, occ, as, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // scoreboard compare
  function automatic void chk(input string name, input int idx,
                              input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endfunction

  task automatic chk_all(input int idx, input vec_t v);
    chk("occupancy", idx, {4'h0, occupancy}, {4'h0, v.occ});
    chk("assigned_spot", idx, {6'h0, assigned_spot}, {6'h0, v.as});
    chk("entry_grant", idx, {7'h0, entry_grant}, {7'h0, v.g});
    chk("entry_deny", idx, {7'h0, entry_deny}, {7'h0, v.d});
    chk("gate_open", idx, {7'h0, gate_open}, {7'h0, v.gt});
    chk("exit_err", idx, {7'h0, exit_err}, {7'h0, v.err});
    chk("full", idx, {7'h0, full}, {7'h0, (v.occ == 4'b1111)});
  endtask

  // driver
  task automatic drive(input logic er, input logic xr, input logic [1:0] xs);
    @(negedge clk);
    entry_req = er;
    exit_req  = xr;
    exit_spot = xs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; entry_req = 1'b0; exit_req = 1'b0; exit_spot = 2'd0;

    // Four cars fill the lot in spot order.
    add_car(4'b0001, 2'd0);
    add_car(4'b0011, 2'd1);
    add_car(4'b0111, 2'd2);
    add_car(4'b1111, 2'd3);
    // Full lot, request held 10 cycles: deny every 4th sample.
    for (int i = 0; i < 10; i++)
      add(1'b1, 1'b0, 2'd0, 4'b1111, 2'd3, 1'b0, (i % 4 == 0), 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 4'b1111, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    // Full plus exit on the request cycle: deny, then the freed spot 0 next cycle.
    add(1'b1, 1'b1, 2'd0, 4'b1110, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    add_car(4'b1111, 2'd0);
    // Exit spot 2 then re-admit into spot 2.
    add(1'b0, 1'b1, 2'd2, 4'b1011, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_car(4'b1111, 2'd2);
    // Down to 0101, then an exit of a free spot.
    add(1'b0, 1'b1, 2'd1, 4'b1101, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd3, 4'b0101, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2'd1, 4'b0101, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 2'd0, 4'b0101, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    // Allocation and exit on one edge: spot 1 from pre-edge state, spot 0 freed.
    add(1'b1, 1'b1, 2'd0, 4'b0110, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 2'd2, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < GATE; i++) add(1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 2'd0, 4'b0010, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    add_car(4'b0011, 2'd0);
    add(1'b0, 1'b1, 2'd1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state.
    #1;
    chk("rst_occupancy", 0, {4'h0, occupancy}, 8'h00);
    chk("rst_assigned", 0, {6'h0, assigned_spot}, 8'h00);
    chk("rst_pulses", 0, {5'h0, entry_grant, entry_deny, exit_err}, 8'h00);
    chk("rst_gate", 0, {7'h0, gate_open}, 8'h00);
    chk("rst_state", 0, {6'h0, dbg_state}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].er, vecs[i].xr, vecs[i].xs);
      chk_all(i, vecs[i]);
    end

    // Reset while the gate is open with occupancy 0011.
    drive(1'b1, 1'b0, 2'd0);
    chk("seq_grant", 100, {7'h0, entry_grant}, 8'h01);
    chk("seq_spot", 100, {6'h0, assigned_spot}, 8'h01);
    chk("seq_occ", 100, {4'h0, occupancy}, 8'h03);
    drive(1'b1, 1'b0, 2'd0);
    chk("seq_gate_up", 101, {7'h0, gate_open}, 8'h01);
    chk("seq_state_open", 101, {6'h0, dbg_state}, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gate", 102, {7'h0, gate_open}, 8'h00);
    chk("async_occ", 102, {4'h0, occupancy}, 8'h00);
    chk("async_state", 102, {6'h0, dbg_state}, 8'h00);
    chk("async_full", 102, {7'h0, full}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", 103, {7'h0, entry_grant}, 8'h01);
    chk("post_rst_spot", 103, {6'h0, assigned_spot}, 8'h00);
    chk("post_rst_occ", 103, {4'h0, occupancy}, 8'h01);
    drive(1'b0, 1'b0, 2'd0);
    chk("post_rst_pulse", 104, {7'h0, entry_grant}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
